// File: rtl/xmpl_dsp_seq_pkg.sv
// xmpl_dsp_seq_pkg: shared FSM states, status bit positions and command layout for the sequencer
package xmpl_dsp_seq_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int ACK_BIT = 0;
   localparam int ERR_BIT = 1;
   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  len;
   } cmd_t;
endpackage

// File: rtl/xmpl_dsp_seq_fifo.sv
// xmpl_dsp_seq_fifo: command FIFO with registered full/empty flags
// Ports: clk_i/reset_n_i clock and async active-low reset; push/wdata enqueue;
//        pop dequeues; rdata shows the head entry; full/empty occupancy flags.
module xmpl_dsp_seq_fifo
   import xmpl_dsp_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic push,
   input  logic pop,
   input  cmd_t wdata,
   output cmd_t rdata,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   cmd_t          mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count, count_n;
   logic          do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // a simultaneous push and pop leaves the occupancy unchanged
   assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign rdata   = mem[rptr];
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr + AW'(do_push);
         rptr  <= rptr + AW'(do_pop);
         count <= count_n;
         full  <= count_n == (AW+1)'(DEPTH);
         empty <= count_n == '0;
      end
   always_ff @(posedge clk_i)
      if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/xmpl_dsp_seq.sv
// xmpl_dsp_seq: expands queued write commands into strobe bursts toward msf and reports one response per command
// Ports: cmd_* valid/ready command intake; msf_a/b/c_o beat strobe, index and data;
//        msf_status_i ack/error status; rsp_* one-cycle response; busy_o activity flag.
module xmpl_dsp_seq
   import xmpl_dsp_seq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [11:0] cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   input  logic [3:0]  cmd_len_i,
   output logic        msf_a_o,
   output logic [11:0] msf_b_o,
   output logic [31:0] msf_c_o,
   input  logic [31:0] msf_status_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_status_o,
   output logic        rsp_timeout_o,
   output logic        busy_o
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   state_t        state, state_n;
   cmd_t          head;
   logic          full, empty, pop, ack, done, expire, timeout;
   logic [11:0]   addr;
   logic [31:0]   data, status;
   logic [3:0]    len, beat;
   logic [TW-1:0] timer;
   xmpl_dsp_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push      (cmd_valid_i && cmd_ready_o),
      .pop       (pop),
      .wdata     ({cmd_addr_i, cmd_data_i, cmd_len_i}),
      .rdata     (head),
      .full      (full),
      .empty     (empty)
   );
   assign pop           = state == IDLE && !empty;
   assign ack           = msf_status_i[ACK_BIT];
   assign done          = msf_status_i[ERR_BIT] || beat == len;
   assign expire        = timer == TW'(TIMEOUT_CYC - 1);
   assign cmd_ready_o   = !full;
   assign msf_a_o       = state == ISSUE;
   assign msf_b_o       = addr;
   assign msf_c_o       = data;
   assign rsp_valid_o   = state == RESP;
   assign rsp_status_o  = status;
   assign rsp_timeout_o = timeout;
   assign busy_o        = state != IDLE || !empty;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = empty ? IDLE : ISSUE;
         ISSUE:   state_n = WAIT;
         WAIT:    state_n = ack ? (done ? RESP : ISSUE) : (expire ? RESP : WAIT);
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state   <= IDLE;
         addr    <= '0;
         data    <= '0;
         len     <= '0;
         beat    <= '0;
         timer   <= '0;
         status  <= '0;
         timeout <= 1'b0;
      end else begin
         state <= state_n;
         if (pop) begin
            addr    <= head.addr;
            data    <= head.data;
            len     <= head.len;
            beat    <= '0;
            timer   <= '0;
            status  <= '0;
            timeout <= 1'b0;
         end else if (state == WAIT) begin
            if (ack) begin
               status <= msf_status_i;
               // the timer restarts so every beat gets its own full wait budget
               if (!done) begin
                  beat  <= beat + 4'd1;
                  addr  <= addr + 12'd1;
                  data  <= data + 32'd1;
                  timer <= '0;
               end
            end else if (expire) timeout <= 1'b1;
            else timer <= timer + TW'(1);
         end
      end
endmodule

// File: tb/tb_xmpl_dsp_seq.sv
// tb_xmpl_dsp_seq: directed scoreboard bench for the command sequencer
module tb_xmpl_dsp_seq;
   logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0;
   logic [11:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0, msf_status = '0;
   logic [3:0]  cmd_len = '0;
   logic        cmd_ready_o, msf_a_o, rsp_valid_o, rsp_timeout_o, busy_o;
   logic [11:0] msf_b_o;
   logic [31:0] msf_c_o, rsp_status_o;
   int          checks = 0, failures = 0, n_strobe = 0, n_rsp = 0, extra = 0;
   int          n, acc, s0, r0;
   logic [43:0] exp_s[$];
   logic [32:0] exp_r[$];

   xmpl_dsp_seq #(.FIFO_DEPTH(4), .TIMEOUT_CYC(255)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_addr_i    (cmd_addr),
      .cmd_data_i    (cmd_data),
      .cmd_len_i     (cmd_len),
      .msf_a_o       (msf_a_o),
      .msf_b_o       (msf_b_o),
      .msf_c_o       (msf_c_o),
      .msf_status_i  (msf_status),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_status_o  (rsp_status_o),
      .rsp_timeout_o (rsp_timeout_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (msf_a_o) begin
         n_strobe++;
         if (exp_s.size() > 0) chk("strobe_bc", {msf_b_o, msf_c_o}, exp_s.pop_front());
         else extra++;
      end
      if (rsp_valid_o) begin
         n_rsp++;
         if (exp_r.size() > 0) chk("rsp_tmo_status", {rsp_timeout_o, rsp_status_o}, exp_r.pop_front());
         else extra++;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic push_cmd(input logic [11:0] a, input logic [31:0] d, input logic [3:0] l);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_len   = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_strobe(input string tag, output int cnt);
      cnt = 0;
      while (!msf_a_o && cnt < 400) begin
         tick();
         cnt++;
      end
      chk(tag, msf_a_o, 1);
   endtask

   task automatic ack(input logic [31:0] st);
      msf_status = st;
      tick();
      msf_status = '0;
   endtask

   initial begin
      ticks(2);
      chk("reset_ready", cmd_ready_o, 1);
      chk("reset_strobe", msf_a_o, 0);
      chk("reset_bc", {msf_b_o, msf_c_o}, 0);
      chk("reset_rsp", {rsp_valid_o, rsp_timeout_o, rsp_status_o}, 0);
      chk("reset_busy", busy_o, 0);
      reset_n = 1'b1;
      tick();
      // single beat, ack three cycles after the strobe
      exp_s.push_back({12'h010, 32'hDEADBEEF});
      exp_r.push_back({1'b0, 32'h1});
      push_cmd(12'h010, 32'hDEADBEEF, 4'd0);
      wait_strobe("single_strobe", n);
      chk("single_latency", n, 1);
      ticks(3);
      ack(32'h1);
      chk("single_rsp_valid", rsp_valid_o, 1);
      chk("single_rsp_tmo", rsp_timeout_o, 0);
      ticks(2);
      chk("single_rsp_count", n_rsp, 1);
      chk("single_idle", busy_o, 0);
      // burst with address and data wrap, ack one cycle after each strobe
      r0 = n_rsp;
      exp_s.push_back({12'hFFE, 32'hFFFFFFFF});
      exp_s.push_back({12'hFFF, 32'h00000000});
      exp_s.push_back({12'h000, 32'h00000001});
      exp_s.push_back({12'h001, 32'h00000002});
      exp_r.push_back({1'b0, 32'h1});
      push_cmd(12'hFFE, 32'hFFFFFFFF, 4'd3);
      for (int i = 0; i < 4; i++) begin
         wait_strobe("burst_strobe", n);
         if (i > 0) chk("burst_period", n, 0);
         tick();
         ack(32'h1);
      end
      chk("burst_rsp_valid", rsp_valid_o, 1);
      ticks(3);
      chk("burst_rsp_count", n_rsp - r0, 1);
      // no ack: timeout response at s+256
      exp_s.push_back({12'h100, 32'h5});
      exp_r.push_back({1'b1, 32'h0});
      push_cmd(12'h100, 32'h5, 4'd0);
      wait_strobe("tmo_strobe", n);
      ticks(255);
      chk("tmo_not_early", rsp_valid_o, 0);
      tick();
      chk("tmo_rsp_valid", rsp_valid_o, 1);
      chk("tmo_flag", rsp_timeout_o, 1);
      ticks(2);
      // ack in the last wait cycle wins over timeout
      exp_s.push_back({12'h101, 32'h6});
      exp_r.push_back({1'b0, 32'h1});
      push_cmd(12'h101, 32'h6, 4'd0);
      wait_strobe("late_strobe", n);
      ticks(255);
      ack(32'h1);
      chk("late_rsp_valid", rsp_valid_o, 1);
      chk("late_tmo_flag", rsp_timeout_o, 0);
      ticks(2);
      // error on third beat aborts remaining beats
      s0 = n_strobe;
      exp_s.push_back({12'h200, 32'h10});
      exp_s.push_back({12'h201, 32'h11});
      exp_s.push_back({12'h202, 32'h12});
      exp_r.push_back({1'b0, 32'h3});
      push_cmd(12'h200, 32'h10, 4'd7);
      for (int i = 0; i < 3; i++) begin
         wait_strobe("err_strobe", n);
         tick();
         ack(i == 2 ? 32'h3 : 32'h1);
      end
      chk("err_rsp_valid", rsp_valid_o, 1);
      chk("err_rsp_status", rsp_status_o, 32'h3);
      ticks(6);
      chk("err_strobe_count", n_strobe - s0, 3);
      // backpressure with ack held low
      acc = 0;
      for (int i = 0; i < 7; i++) begin
         cmd_valid = 1'b1;
         cmd_addr  = 12'h300 + 12'(acc);
         cmd_data  = 32'h1000 + 32'(acc);
         cmd_len   = 4'd0;
         if (cmd_ready_o) begin
            exp_s.push_back({cmd_addr, cmd_data});
            exp_r.push_back({1'b1, 32'h0});
            acc++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      chk("bp_accepted", acc, 5);
      chk("bp_ready_low", cmd_ready_o, 0);
      n = 0;
      while (!rsp_valid_o && n < 400) begin
         tick();
         n++;
      end
      chk("bp_first_rsp", rsp_valid_o, 1);
      chk("bp_ready_still_low", cmd_ready_o, 0);
      ticks(2);
      chk("bp_ready_rise", cmd_ready_o, 1);
      n = 0;
      while (busy_o && n < 3000) begin
         tick();
         n++;
      end
      chk("bp_drain", busy_o, 0);
      // reset during the wait of beat 2
      s0 = n_strobe;
      r0 = n_rsp;
      exp_s.push_back({12'h400, 32'h20});
      exp_s.push_back({12'h401, 32'h21});
      push_cmd(12'h400, 32'h20, 4'd3);
      wait_strobe("rst_strobe1", n);
      tick();
      ack(32'h1);
      wait_strobe("rst_strobe2", n);
      ticks(2);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_strobe", msf_a_o, 0);
      chk("rst_async_bc", {msf_b_o, msf_c_o}, 0);
      chk("rst_async_rsp", {rsp_valid_o, rsp_timeout_o, rsp_status_o}, 0);
      chk("rst_async_ready", cmd_ready_o, 1);
      chk("rst_async_busy", busy_o, 0);
      ticks(2);
      reset_n = 1'b1;
      ticks(20);
      chk("rst_strobe_count", n_strobe - s0, 2);
      chk("rst_no_rsp", n_rsp - r0, 0);
      chk("rst_ready", cmd_ready_o, 1);
      chk("no_extra", extra, 0);
      chk("exp_s_drained", exp_s.size(), 0);
      chk("exp_r_drained", exp_r.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/xmpl_dsp_seq.md
# xmpl_dsp_seq

Command sequencer directly upstream of `xmpl_dsp_msf`. It accepts buffered write commands on a valid/ready port, expands each command into a burst of single-cycle strobes on the `msf` a/b/c inputs, and waits for an acknowledge on the `msf` status word after every beat. It reports one response per command: last status, error, or timeout.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `TIMEOUT_CYC`, 255: maximum WAIT cycles per beat, 1..1023.

Ports:
- `clk_i` in 1: single clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: FIFO not full.
- `cmd_addr_i` in 12: start index.
- `cmd_data_i` in 32: first-beat data.
- `cmd_len_i` in 4: beats minus one (0..15 gives 1..16 beats).
- `msf_a_o` out 1: one-cycle strobe, drives `xmpl_dsp_msf_a_i`.
- `msf_b_o` out 12: beat index, drives `xmpl_dsp_msf_b_i`.
- `msf_c_o` out 32: beat data, drives `xmpl_dsp_msf_c_0`.
- `msf_status_i` in 32: `msf` status. Bit 0 = ack pulse, bit 1 = error.
- `rsp_valid_o` out 1: one-cycle response pulse. No backpressure.
- `rsp_status_o` out 32: last captured status.
- `rsp_timeout_o` out 1: the command ended by timeout.
- `busy_o` out 1: FSM not in IDLE, or FIFO not empty.

## Operation
- FIFO push occurs on `cmd_valid_i && cmd_ready_o`. `cmd_ready_o = !full`, registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty: pop and load addr, data and len; clear beat and timer; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `msf_a_o` = 1 with registered `msf_b_o`/`msf_c_o` stable; go to WAIT next cycle. Ack is not sampled in ISSUE.
- WAIT: each cycle, in priority order:
  1. If ack: capture `msf_status_i`. If error, or beat == len, go to RESP. Otherwise beat+1, addr+1, data+1, go to ISSUE.
  2. Else if timer == `TIMEOUT_CYC`-1: set the timeout flag and go to RESP.
  3. Else timer+1.
- RESP: `rsp_valid_o` = 1 for one cycle with `rsp_status_o` and `rsp_timeout_o`. Go to IDLE. The timeout flag is cleared on the next load.
- Arithmetic:
  - addr wraps modulo 2^12 (0xFFF → 0x000).
  - data wraps modulo 2^32.
  - timer width is $clog2(`TIMEOUT_CYC`+1).
- On error, the remaining beats of that command are dropped.
- On timeout, `rsp_status_o` holds the status captured on the last acked beat, or 0 if no beat was acked.
- `msf_b_o`/`msf_c_o` hold their last value outside ISSUE.
- Reset values:
  - All outputs 0 except `cmd_ready_o` = 1.
  - FIFO empty, FSM in IDLE.
- Reset mid-operation: the FIFO is flushed and `msf_a_o` drops immediately. No response is produced for in-flight commands.

## Timing
- Command accepted at edge N → strobe asserted in cycle N+2 when the FSM is idle and the FIFO is empty.
- Strobe in cycle s → WAIT occupies cycles s+1 onward.
- Ack in cycle k → next strobe in cycle k+1, or `rsp_valid_o` in cycle k+1 after the last beat.
- No ack → `rsp_valid_o` with timeout in cycle s+`TIMEOUT_CYC`+1.
- An ack in the last WAIT cycle (s+`TIMEOUT_CYC`) wins over timeout.
- Simultaneous push and pop: both take effect in the same cycle, and the count is unchanged.
- Pipeline capacity: `FIFO_DEPTH` queued commands + 1 command in the FSM.
- Minimum per-beat period: 2 cycles (ISSUE + one WAIT cycle).

## Structure
- `xmpl_dsp_seq_pkg`:
  - FSM state enum.
  - `ACK_BIT` = 0, `ERR_BIT` = 1.
  - Packed command struct {addr[12], data[32], len[4]}, 48 bits.
- Sub-module `xmpl_dsp_seq_fifo`: synchronous FIFO of command structs with full/empty flags and pointer wrap. It is parameterised by `FIFO_DEPTH`, with the same clock and async reset.
- The top level contains the FSM, beat/address/data/timer registers and the response register.

## Test plan
- **Single beat:** addr 0x010, data 0xDEADBEEF, len 0; ack 3 cycles after the strobe with status 0x00000001.
  - Expect one strobe with b=0x010, c=0xDEADBEEF.
  - Expect `rsp_valid_o` with status 0x1 and timeout 0.
- **Burst wrap:** addr 0xFFE, data 0xFFFFFFFF, len 3; ack every beat after 1 cycle.
  - Expect b = 0xFFE, 0xFFF, 0x000, 0x001 and c = 0xFFFFFFFF, 0, 1, 2.
  - Expect exactly one response.
- **Timeout:** `TIMEOUT_CYC`=255, no ack → timeout response in cycle s+256.
  - Rerun with the ack at s+255: expect a normal response with timeout 0.
- **Error abort:** len 7; status 0x3 on the third beat's ack.
  - Expect exactly 3 strobes.
  - Expect `rsp_status_o` = 0x3 and timeout 0.
- **Backpressure:** hold ack low and push back-to-back commands.
  - Expect `cmd_ready_o` to fall after 5 accepted commands (`FIFO_DEPTH` 4).
  - Expect it to rise 1 cycle after the first response pops an entry.
- **Reset mid-burst:** pull `reset_n_i` low during WAIT of beat 2.
  - Expect all outputs at reset values asynchronously.
  - After release: `cmd_ready_o` = 1, no `rsp_valid_o`, no strobes.
